// File: rtl/mdu_if.sv
// Handshake bundle between the execute stage and the multiply/divide sequencer.
interface mdu_if #(
    parameter int WIDTH = 64
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             word;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             busy;

    modport master (
        output flush, in_valid, op, word, a, b, out_ready,
        input  in_ready, out_valid, c, busy
    );

    modport slave (
        input  flush, in_valid, op, word, a, b, out_ready,
        output in_ready, out_valid, c, busy
    );
endinterface

// File: rtl/mdu_ctrl.sv
// RV64M multiply/divide sequencer: one shift-add or restoring-divide step per cycle,
// result held until the pipeline takes it.
module mdu_ctrl #(
    parameter int WIDTH = 64
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] ITER_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] ITER_HALF = CW'(HALF);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state, w_next;
    logic             r_isDiv, r_isRem, r_word, r_qNeg, r_rNeg, r_special;
    logic [WIDTH-1:0] r_specVal, r_q, r_rem, r_d, r_c;
    logic [CW-1:0]    r_cnt;

    logic             w_inReady, w_accept, w_isDiv, w_isUns, w_isRem, w_signedDiv;
    logic             w_aNeg, w_bNeg, w_divZero, w_ovf, w_iterDone;
    logic [WIDTH-1:0] w_aExt, w_bExt, w_aMag, w_bMag, w_min, w_specVal;
    logic [WIDTH:0]   w_shift, w_trial;
    logic [WIDTH-1:0] w_quot, w_quotS, w_remS, w_raw, w_result;

    assign w_inReady = (r_state == IDLE) && !bus.flush;
    assign w_accept  = bus.in_valid && w_inReady;

    // Operand conditioning at accept: width/sign extension, magnitudes and the
    // two divide corner cases that bypass iteration entirely.
    always_comb begin
        w_isDiv     = bus.op[2];
        w_isUns     = bus.op[2] & bus.op[0];
        w_isRem     = bus.op[2] & bus.op[1];
        w_signedDiv = w_isDiv & ~w_isUns;
        w_aExt      = bus.a;
        w_bExt      = bus.b;
        if (bus.word) begin
            w_aExt = w_isUns ? {{HALF{1'b0}}, bus.a[HALF-1:0]} : {{HALF{bus.a[HALF-1]}}, bus.a[HALF-1:0]};
            w_bExt = w_isUns ? {{HALF{1'b0}}, bus.b[HALF-1:0]} : {{HALF{bus.b[HALF-1]}}, bus.b[HALF-1:0]};
        end
        w_aNeg    = w_signedDiv & w_aExt[WIDTH-1];
        w_bNeg    = w_signedDiv & w_bExt[WIDTH-1];
        w_aMag    = w_aNeg ? -w_aExt : w_aExt;
        w_bMag    = w_bNeg ? -w_bExt : w_bExt;
        w_min     = bus.word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(WIDTH-1){1'b0}}};
        w_divZero = w_isDiv && (w_bExt == '0);
        w_ovf     = w_signedDiv && (w_aExt == w_min) && (&w_bExt);
        w_specVal = w_divZero ? (w_isRem ? w_aExt : '1) : (w_isRem ? '0 : w_min);
    end

    always_comb begin
        w_iterDone = (r_cnt == (r_word ? ITER_HALF : ITER_FULL));
        w_shift    = {r_rem, r_q[WIDTH-1]};
        w_trial    = w_shift - {1'b0, r_d};
        w_quot     = r_word ? {{HALF{1'b0}}, r_q[HALF-1:0]} : r_q;
        w_quotS    = r_qNeg ? -w_quot : w_quot;
        w_remS     = r_rNeg ? -r_rem : r_rem;
        w_raw      = r_special ? r_specVal : (!r_isDiv ? r_rem : (r_isRem ? w_remS : w_quotS));
        w_result   = r_word ? {{HALF{w_raw[HALF-1]}}, w_raw[HALF-1:0]} : w_raw;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CALC;
            CALC:    if (r_special || w_iterDone) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (bus.flush) w_next = IDLE;
    end

    // Multiply reuses r_rem as accumulator, r_d as shifting multiplicand and
    // r_q as shifting multiplier; divide keeps the dividend in the top of r_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_isDiv   <= 1'b0;
            r_isRem   <= 1'b0;
            r_word    <= 1'b0;
            r_qNeg    <= 1'b0;
            r_rNeg    <= 1'b0;
            r_special <= 1'b0;
            r_specVal <= '0;
            r_q       <= '0;
            r_rem     <= '0;
            r_d       <= '0;
            r_c       <= '0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_isDiv   <= w_isDiv;
            r_isRem   <= w_isRem;
            r_word    <= bus.word;
            r_qNeg    <= w_aNeg ^ w_bNeg;
            r_rNeg    <= w_aNeg;
            r_special <= w_divZero | w_ovf;
            r_specVal <= w_specVal;
            r_rem     <= '0;
            r_cnt     <= '0;
            if (w_isDiv) begin
                r_q <= bus.word ? {w_aMag[HALF-1:0], {HALF{1'b0}}} : w_aMag;
                r_d <= w_bMag;
            end else begin
                r_q <= w_bExt;
                r_d <= w_aExt;
            end
        end else if (r_state == CALC && !bus.flush) begin
            if (r_special || w_iterDone) begin
                r_c <= w_result;
            end else begin
                r_cnt <= r_cnt + CW'(1);
                if (r_isDiv) begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (r_q[0]) r_rem <= r_rem + r_d;
                    r_d <= {r_d[WIDTH-2:0], 1'b0};
                    r_q <= {1'b0, r_q[WIDTH-1:1]};
                end
            end
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.c         = r_c;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases, then random traffic
// compared every cycle against an arithmetic reference with a latency budget.
module tb_mdu_ctrl;
    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    mdu_if #(.WIDTH(64)) bus ();

    mdu_ctrl #(.WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Architectural result from plain integer arithmetic with RISC-V corner rules.
    function automatic logic [63:0] refResult(input logic [2:0] op, input logic word,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [63:0]     r;
        logic [31:0]     w;
        int              sa, sb;
        int unsigned     ua, ub;
        longint          la, lb;
        longint unsigned xa, xb;
        r = '0;
        w = '0;
        if (!op[2]) begin
            r = a * b;
            if (word) r = {{32{r[31]}}, r[31:0]};
        end else if (word) begin
            if (op[0]) begin
                ua = a[31:0];
                ub = b[31:0];
                if (ub == 0) w = op[1] ? ua : 32'hFFFF_FFFF;
                else         w = op[1] ? ua % ub : ua / ub;
            end else begin
                sa = a[31:0];
                sb = b[31:0];
                if (sb == 0)                                w = op[1] ? sa : 32'hFFFF_FFFF;
                else if (sa == int'(32'h8000_0000) && sb == -1) w = op[1] ? 32'h0 : sa;
                else                                        w = op[1] ? sa % sb : sa / sb;
            end
            r = {{32{w[31]}}, w};
        end else begin
            if (op[0]) begin
                xa = a;
                xb = b;
                if (xb == 0) r = op[1] ? xa : 64'hFFFF_FFFF_FFFF_FFFF;
                else         r = op[1] ? xa % xb : xa / xb;
            end else begin
                la = a;
                lb = b;
                if (lb == 0)                                          r = op[1] ? la : 64'hFFFF_FFFF_FFFF_FFFF;
                else if (la == longint'(64'h8000_0000_0000_0000) && lb == -1) r = op[1] ? 64'h0 : la;
                else                                                  r = op[1] ? la % lb : la / lb;
            end
        end
        return r;
    endfunction

    // Cycles from the accept edge to out_valid.
    function automatic int refLatency(input logic [2:0] op, input logic word,
                                      input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf;
        zero = word ? (b[31:0] == 32'h0) : (b == 64'h0);
        ovf  = !op[0] && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                               : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
        if (op[2] && (zero || ovf)) return 1;
        return word ? 33 : 65;
    endfunction

    // Reference timeline: what the unit must be showing after each edge.
    logic        mBusy, mDone;
    int          mCount;
    logic [63:0] mResult;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mBusy = 1'b0; mDone = 1'b0; mCount = 0; mResult = '0;
        end else if (bus.flush) begin
            mBusy = 1'b0; mDone = 1'b0;
        end else if (!mBusy) begin
            if (bus.in_valid) begin
                mBusy   = 1'b1;
                mDone   = 1'b0;
                mResult = refResult(bus.op, bus.word, bus.a, bus.b);
                mCount  = refLatency(bus.op, bus.word, bus.a, bus.b);
            end
        end else if (!mDone) begin
            mCount--;
            if (mCount == 0) mDone = 1'b1;
        end else if (bus.out_ready) begin
            mBusy = 1'b0; mDone = 1'b0;
        end
    end

    always @(negedge clk) begin
        #2;
        if (!reset) begin
            checkOutput("cmp out_valid", 64'(bus.out_valid), 64'(mDone));
            checkOutput("cmp busy", 64'(bus.busy), 64'(mBusy));
            checkOutput("cmp in_ready", 64'(bus.in_ready), 64'(!mBusy && !bus.flush));
            if (mDone) checkOutput("cmp c", bus.c, mResult);
        end
    end

    function automatic logic [63:0] randOperand();
        case ($urandom_range(0, 8))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h0000_0000_8000_0000;
            4:       return 64'($urandom_range(0, 20));
            5:       return {32'hFFFF_FFFF, $urandom};
            6:       return {$urandom, 32'hFFFF_FFFF};
            7:       return 64'($urandom);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic applyStimulus(input string name, input logic [2:0] op, input logic word,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] expC, input int expLat, input int hold);
        int n;
        @(negedge clk);
        bus.op = op; bus.word = word; bus.a = a; bus.b = b;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = {$urandom, $urandom};
        bus.b = {$urandom, $urandom};
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        checkOutput({name, " latency"}, 64'(n), 64'(expLat));
        checkOutput({name, " c"}, bus.c, expC);
        repeat (hold) begin
            @(negedge clk);
            checkOutput({name, " held valid"}, 64'(bus.out_valid), 64'h1);
            checkOutput({name, " held c"}, bus.c, expC);
            checkOutput({name, " held in_ready"}, 64'(bus.in_ready), 64'h0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({name, " handoff valid"}, 64'(bus.out_valid), 64'h0);
        checkOutput({name, " handoff busy"}, 64'(bus.busy), 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected end before 1000000");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = '0; bus.word = 1'b0;
        bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
        reset = 1'b1;
        #3;
        checkOutput("reset in_ready", 64'(bus.in_ready), 64'h1);
        checkOutput("reset out_valid", 64'(bus.out_valid), 64'h0);
        checkOutput("reset busy", 64'(bus.busy), 64'h0);
        checkOutput("reset c", bus.c, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        checkOutput("model MUL", refResult(3'd0, 1'b0, 64'd7, -64'sd3), 64'hFFFF_FFFF_FFFF_FFEB);
        checkOutput("model DIV", refResult(3'd4, 1'b0, -64'sd7, 64'd2), -64'sd3);
        checkOutput("model REM", refResult(3'd6, 1'b0, -64'sd7, 64'd2), -64'sd1);
        checkOutput("model DIVW ovf", refResult(3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF), 64'hFFFF_FFFF_8000_0000);
        checkOutput("model REMU zero", refResult(3'd7, 1'b0, 64'd5, 64'd0), 64'd5);

        applyStimulus("MUL", 3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
        applyStimulus("DIV", 3'd4, 1'b0, -64'sd7, 64'd2, -64'sd3, 65, 0);
        applyStimulus("REM", 3'd6, 1'b0, -64'sd7, 64'd2, -64'sd1, 65, 0);
        applyStimulus("DIVU", 3'd5, 1'b0, 64'd7, 64'd2, 64'd3, 65, 0);
        applyStimulus("DIVW ovf", 3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
        applyStimulus("REMW ovf", 3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 1, 0);
        applyStimulus("DIVU zero", 3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        applyStimulus("REMU zero", 3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
        applyStimulus("DIV 64 ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                      64'h8000_0000_0000_0000, 1, 0);
        applyStimulus("REMUW", 3'd7, 1'b1, 64'hDEAD_0000_FFFF_FFF1, 64'h1234_0000_0000_0010, 64'h1, 33, 0);

        // Flush ten cycles into a multiply, then a word multiply must still work.
        @(negedge clk);
        bus.op = 3'd0; bus.word = 1'b0; bus.a = 64'd9; bus.b = 64'd9; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checkOutput("flush busy", 64'(bus.busy), 64'h0);
        checkOutput("flush out_valid", 64'(bus.out_valid), 64'h0);
        applyStimulus("MULW after flush", 3'd0, 1'b1, 64'd3, 64'd4, 64'd12, 33, 5);

        // Flush beats a simultaneous request.
        @(negedge clk);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.op = 3'd4;
        #2;
        checkOutput("flush in_ready", 64'(bus.in_ready), 64'h0);
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        checkOutput("flush+valid busy", 64'(bus.busy), 64'h0);

        // Flush while a result is waiting discards it.
        @(negedge clk);
        bus.op = 3'd5; bus.word = 1'b0; bus.a = 64'd1; bus.b = 64'd0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("done before flush", 64'(bus.out_valid), 64'h1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checkOutput("flush in DONE", 64'(bus.out_valid), 64'h0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        bus.op = 3'd4; bus.word = 1'b0; bus.a = 64'd1000; bus.b = 64'd7; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("async reset out_valid", 64'(bus.out_valid), 64'h0);
        checkOutput("async reset busy", 64'(bus.busy), 64'h0);
        checkOutput("async reset in_ready", 64'(bus.in_ready), 64'h1);
        checkOutput("async reset c", bus.c, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        repeat (6000) begin
            @(negedge clk);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.op        = 3'($urandom_range(0, 7));
            bus.word      = 1'($urandom_range(0, 1));
            bus.a         = randOperand();
            bus.b         = randOperand();
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        repeat (80) @(negedge clk);
        checkOutput("drain idle", 64'(bus.busy), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
